// File: rtl/lsu_bus.sv
// ---------------------------------------------------------------------------
// lsu_bus -- load/store unit bus adapter.
//
// Turns a single-cycle memread/memwrite request from the decoder into a
// request/acknowledge bus transaction. The datapath is stalled while the
// access is outstanding. Every access passes through IDLE -> REQ -> DONE,
// and the datapath commits at the end of DONE. If no mem_ack arrives within
// MAX_WAIT REQ cycles, the access is abandoned with a one-cycle err in DONE.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   When defined, an access with aluout[1:0] != 0 skips the bus. It goes
//   straight to DONE with err=1. When undefined, the low address bits are
//   dropped and the access proceeds word-aligned.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   memread, memwrite   - load / store request from decoder (both = store)
//   aluout              - byte address
//   writedata_rd2       - store data
//   readdata_rd         - load result, held until the next completed load
//   stall               - freezes pc / regfile write while the access is open
//   err                 - one-cycle timeout / misalignment flag (in DONE)
//   mem_req/we/addr/wdata, mem_ack, mem_rdata - memory bus
// ---------------------------------------------------------------------------
module lsu_bus #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata_rd2,
    output logic [31:0] readdata_rd,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Last REQ cycle index before the counter would reach MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic access;
    logic misalign;

    assign access   = memread | memwrite;
    assign misalign = TRAP_EN & (|aluout[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;      // err lives only for the DONE cycle it is set into
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall   = 1'b0;
        mem_req = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (misalign) begin
                        // Trap: bus untouched, readdata_rd kept.
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        wait_d  = '0;
                        addr_d  = {aluout[31:2], 2'b00};
                        wdata_d = writedata_rd2;
                        we_d    = memwrite;   // load+store together = store
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata;
                end else if (wait_q == WAIT_LAST) begin
                    // Ack missing for MAX_WAIT cycles: give up.
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                // Always one cycle, so the next instruction decodes fresh.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign readdata_rd = rdata_q;
    assign err         = err_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
module tb_lsu_bus;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [31:0] aluout = '0, writedata_rd2 = '0;
    logic [31:0] readdata_rd;
    logic        stall, err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_rd;

    lsu_bus #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .aluout(aluout), .writedata_rd2(writedata_rd2), .readdata_rd(readdata_rd),
        .stall(stall), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] a, wd;
        int          dly;      // REQ cycle index carrying ack; >= MW means never
        logic [31:0] rdat;
        int          exp_reqs;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    // Transaction-level reference: how many REQ cycles, err, resulting readdata.
    function automatic void model(input logic wr, input logic [31:0] a, input int dly,
                                  input logic [31:0] rdat, output int reqs,
                                  output logic e, output logic [31:0] rdo);
        bit trap;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a[1:0] != 2'b00);
`else
        trap = 1'b0;
`endif
        if (trap) begin
            reqs = 0; e = 1'b1; rdo = mdl_rd;
        end else if (dly < MW) begin
            reqs = dly + 1; e = 1'b0; rdo = wr ? mdl_rd : rdat;
        end else begin
            reqs = MW; e = 1'b1; rdo = wr ? mdl_rd : 32'h0;
        end
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input logic [31:0] rdat,
                           input int exp_reqs, input logic exp_err, input logic [31:0] exp_rd);
        int k;
        logic [31:0] ea;
        ea = {a[31:2], 2'b00};
        memread = rd; memwrite = wr; aluout = a; writedata_rd2 = wd;
        mem_ack = 1'(($urandom & 1));   // ignored in IDLE
        mem_rdata = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        k = 0;
        while (mem_req === 1'b1 && k < 40) begin
            chk("req_addr", mem_addr, ea);
            chk("req_we", 32'(mem_we), 32'(wr));
            chk("req_wdata", mem_wdata, wd);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_err", 32'(err), 32'd0);
            mem_ack   = (k == dly);
            mem_rdata = (k == dly) ? rdat : $urandom;
            @(negedge clk);
            k++;
        end
        chk("req_cycles", 32'(k), 32'(exp_reqs));
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_rdata", readdata_rd, exp_rd);
        mem_ack = 1'b1; mem_rdata = $urandom;   // ignored in DONE
        memread = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        chk("post_stall", 32'(stall), 32'd0);
        chk("post_req", 32'(mem_req), 32'd0);
        chk("post_err", 32'(err), 32'd0);
        chk("post_rdata", readdata_rd, exp_rd);
        mem_ack = 1'b0;
    endtask

    initial begin
        int reqs;
        logic e;
        logic [31:0] rdo, a;
        logic rd, wr;
        int dly;

        vecs[0] = '{1, 0, 32'h100, 32'h0, 0, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D};
        vecs[1] = '{0, 1, 32'h204, 32'h12345678, 3, 32'h0, 4, 0, 32'hCAFEF00D};
        vecs[2] = '{1, 0, 32'h10, 32'h0, 255, 32'h99999999, 4, 1, 32'h0};
        vecs[3] = '{1, 0, 32'hFFFFFFFC, 32'h0, 3, 32'hDEADBEEF, 4, 0, 32'hDEADBEEF};
        vecs[4] = '{0, 1, 32'h20, 32'h0BADCAFE, 255, 32'h0, 4, 1, 32'hDEADBEEF};
        vecs[5] = '{1, 1, 32'h8, 32'hA5A55A5A, 1, 32'h77777777, 2, 0, 32'hDEADBEEF};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[6] = '{1, 0, 32'h102, 32'h0, 0, 32'h11112222, 0, 1, 32'hDEADBEEF};
        vecs[7] = '{0, 1, 32'h13, 32'hFEEDFACE, 2, 32'h0, 0, 1, 32'hDEADBEEF};
`else
        vecs[6] = '{1, 0, 32'h102, 32'h0, 0, 32'h11112222, 1, 0, 32'h11112222};
        vecs[7] = '{0, 1, 32'h13, 32'hFEEDFACE, 2, 32'h0, 3, 0, 32'h11112222};
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdata", readdata_rd, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].dly,
                    vecs[i].rdat, vecs[i].exp_reqs, vecs[i].exp_err, vecs[i].exp_rd);
        end
        mdl_rd = vecs[7].exp_rd;

        // Randomized against the transaction model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            dly = $urandom_range(0, 5);
            rdo = $urandom;
            model(wr, a, dly, rdo, reqs, e, rdo);
            run_txn(rd, wr, a, $urandom, dly, rdo, reqs, e, rdo);
            mdl_rd = rdo;
        end

        // Make readdata_rd nonzero, then reset in the 2nd REQ cycle
        run_txn(1, 0, 32'h40, 32'h0, 0, 32'h0BADF00D, 1, 0, 32'h0BADF00D);
        memread = 1'b1; aluout = 32'h300;
        @(negedge clk);
        chk("mr_req0", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("mr_req1", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; memread = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        #1;
        chk("mr_req_after", 32'(mem_req), 32'd0);
        chk("mr_rdata", readdata_rd, 32'h0);
        chk("mr_addr", mem_addr, 32'h0);
        chk("mr_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mr_late_req", 32'(mem_req), 32'd0);
        chk("mr_late_rdata", readdata_rd, 32'h0);
        chk("mr_late_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the maximum number of REQ-state cycles without mem_ack before a timeout is declared; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 memread  input  1  SHALL be the load request from the main decoder.
REQ-005 memwrite  input  1  SHALL be the store request from the main decoder.
REQ-006 aluout  input  32  SHALL be the byte address computed by the datapath ALU.
REQ-007 writedata_rd2  input  32  SHALL be the store data taken from register file read port 2.
REQ-008 readdata_rd  output  32  SHALL be the load result returned to the datapath result mux.
REQ-009 stall  output  1  SHALL hold the pc register and the register file write while asserted.
REQ-010 err  output  1  SHALL be a one-cycle flag for a bus timeout or misalignment trap.
REQ-011 mem_req  output  1  SHALL be the bus request.
REQ-012 mem_we  output  1  SHALL be the bus write enable.
REQ-013 mem_addr  output  32  SHALL be the word-aligned bus address.
REQ-014 mem_wdata  output  32  SHALL be the bus store data.
REQ-015 mem_ack  input  1  SHALL be the bus completion strobe.
REQ-016 mem_rdata  input  32  SHALL be the bus load data, valid only when mem_ack is high.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-018 IDLE with (memread|memwrite)=1 SHALL transition to REQ and register {aluout[31:2],2'b00} into mem_addr, writedata_rd2 into mem_wdata, and memwrite into mem_we.
REQ-019 When memread=1 and memwrite=1 together, the access SHALL be performed as a store (mem_we=1).
REQ-020 stall SHALL be 1 in IDLE when (memread|memwrite)=1, SHALL be 1 throughout REQ, and SHALL be 0 in DONE and in an idle IDLE.
REQ-021 mem_req SHALL be 1 in every REQ cycle and 0 in every other state; mem_addr, mem_wdata and mem_we SHALL be held stable while mem_req=1.
REQ-022 In REQ with mem_ack=1, the FSM SHALL capture mem_rdata into readdata_rd (load only) and transition to DONE.
REQ-023 A store SHALL leave readdata_rd unchanged.
REQ-024 The minimum latency SHALL be 3 cycles (IDLE, REQ with ack, DONE); the datapath commits at the end of DONE.
REQ-025 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-026 If the wait counter reaches MAX_WAIT with no ack, the FSM SHALL go to DONE with err=1 for that DONE cycle, and a load SHALL return readdata_rd=32'h00000000.
REQ-027 DONE SHALL always return to IDLE after one cycle, regardless of memread/memwrite, so that the next instruction is decoded fresh.
REQ-028 mem_ack SHALL be ignored in IDLE and DONE.
REQ-029 readdata_rd SHALL hold its last value until the next completed load.

Reset
REQ-030 reset SHALL force state=IDLE, wait counter=0, readdata_rd=0, err=0, mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0 on the next rising edge.
REQ-031 Reset asserted mid-REQ SHALL abandon the access; mem_req SHALL be 0 in the first cycle after reset, and a late mem_ack SHALL be ignored.

Configuration
REQ-032 With LSU_MISALIGN_TRAP_EN defined, an access with aluout[1:0]!=2'b00 SHALL skip REQ, go IDLE->DONE, and assert err=1 in DONE; mem_req SHALL stay 0 and readdata_rd SHALL be unchanged.
REQ-033 Without LSU_MISALIGN_TRAP_EN, aluout[1:0] SHALL be silently dropped, the access SHALL proceed normally, and err SHALL assert only on timeout.

Verification
REQ-034 Load, aluout=0x100, mem_ack in the first REQ cycle with mem_rdata=0xCAFEF00D -> mem_addr=0x100; stall=1,1,0; readdata_rd=0xCAFEF00D in DONE.
REQ-035 Store, aluout=0x204, writedata_rd2=0x12345678, ack after 3 wait cycles -> mem_we=1 and mem_wdata stable for 4 REQ cycles; stall low only in DONE.
REQ-036 Load with MAX_WAIT=4 and no ack -> 4 REQ cycles, then DONE with err=1, readdata_rd=0, then IDLE.
REQ-037 Reset asserted in the 2nd REQ cycle, ack in the following cycle -> mem_req=0 after reset; state IDLE; readdata_rd=0.
REQ-038 memread=memwrite=1, aluout=0x8 -> store issued with mem_we=1.
REQ-039 Load at aluout=0x102 -> macro defined: no mem_req, err=1 one cycle; macro undefined: mem_addr=0x100, err=0.
